// File: rtl/fcs_mpc_pkg.sv
// Shared types and constants for the FCS-MPC sample-period sequencer.
package fcs_mpc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV     = 3'd1,
    WAIT_RDY = 3'd2,
    START    = 3'd3,
    COMPUTE  = 3'd4,
    APPLY    = 3'd5,
    FAULT    = 3'd6
  } state_t;

  localparam logic [1:0] FLT_NONE   = 2'b00;
  localparam logic [1:0] FLT_OC     = 2'b01;
  localparam logic [1:0] FLT_ADC_TO = 2'b10;
  localparam logic [1:0] FLT_MPC_TO = 2'b11;

  // Shortest sample period the sequencer will run at, in clocks.
  localparam int unsigned PERIOD_MIN = 8;

endpackage

// File: rtl/fcs_mpc_tick_gen.sv
// Sample-period tick generator: counts 0..P-1 with P = max(period, PERIOD_MIN).
// The period length is sampled at each wrap (and continuously while disabled),
// so a new period value only governs the period that follows the wrap.
module fcs_mpc_tick_gen
  import fcs_mpc_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] len_q;
  logic [PERIOD_W-1:0] len_in;

  // Clamp the requested period and flag the last count of the current period.
  always_comb begin
    len_in = (period < PERIOD_W'(PERIOD_MIN)) ? PERIOD_W'(PERIOD_MIN) : period;
    tick   = enable && (cnt_q == (len_q - PERIOD_W'(1)));
  end

  // Period counter, held at zero while disabled; length reloads at each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      len_q <= PERIOD_W'(PERIOD_MIN);
    end else if (!enable) begin
      cnt_q <= '0;
      len_q <= len_in;
    end else if (tick) begin
      cnt_q <= '0;
      len_q <= len_in;
    end else begin
      cnt_q <= cnt_q + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/fcs_mpc_sequencer.sv
// Sample-period sequencer for the FCS-MPC decision core: ADC trigger and
// capture, overcurrent check, core handshake, minimum-dwell gate drive,
// fault trip and overrun detection.
module fcs_mpc_sequencer
  import fcs_mpc_pkg::*;
#(
  parameter int unsigned PERIOD_W  = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADC_TO    = 64,
  parameter int unsigned MPC_TO    = 32,
  parameter int unsigned MIN_DWELL = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [DATA_W-1:0]   ilim_i,
  input  logic                fault_clr_i,
  output logic                adc_conv_o,
  input  logic                adc_rdy_i,
  input  logic [DATA_W-1:0]   adc_il_i,
  input  logic [DATA_W-1:0]   adc_vc_i,
  input  logic [DATA_W-1:0]   adc_vg_i,
  output logic                mpc_start_o,
  output logic [DATA_W-1:0]   mpc_il_o,
  output logic [DATA_W-1:0]   mpc_vc_o,
  output logic [DATA_W-1:0]   mpc_vg_o,
  input  logic                mpc_done_i,
  input  logic                mpc_u_i,
  output logic                u_o,
  output logic                io_oeb_o,
  output logic                trip_o,
  output logic [1:0]          fault_code_o,
  output logic                overrun_o,
  output logic [15:0]         samples_o
);

  localparam int unsigned TO_MAX = (ADC_TO > MPC_TO) ? ADC_TO : MPC_TO;
  localparam int unsigned TO_W   = $clog2(TO_MAX + 1);
  localparam int unsigned DW_W   = $clog2(MIN_DWELL + 1);

  localparam logic [TO_W-1:0] ADC_LIM   = TO_W'(ADC_TO - 1);
  localparam logic [TO_W-1:0] MPC_LIM   = TO_W'(MPC_TO - 1);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MIN_DWELL);
  localparam logic [DW_W-1:0] DWELL_ONE = DW_W'(1);

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        fault_d;
  logic              tick;
  logic [TO_W-1:0]   to_cnt_q;
  logic [DW_W-1:0]   dwell_q;
  logic              u_lat_q;
  logic              u_q;
  logic              trip_q;
  logic [1:0]        code_q;
  logic              ovr_q;
  logic              oeb_q;
  logic [15:0]       samples_q;
  logic [DATA_W-1:0] il_q;
  logic [DATA_W-1:0] vc_q;
  logic [DATA_W-1:0] vg_q;
  logic              capture;
  logic              apply;
  logic              change;
  logic              fault_entry;
  logic              fault_exit;

  fcs_mpc_tick_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_tick_gen (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .enable (enable_i),
    .period (period_i),
    .tick   (tick)
  );

  // Next-state and fault-cause selection; dropping enable aborts any
  // non-fault state back to IDLE.
  always_comb begin
    state_d = state_q;
    fault_d = FLT_NONE;
    case (state_q)
      IDLE:     if (tick) state_d = CONV;
      CONV:     state_d = WAIT_RDY;
      WAIT_RDY: begin
        if (adc_rdy_i) begin
          if (adc_il_i >= ilim_i) begin
            state_d = FAULT;
            fault_d = FLT_OC;
          end else begin
            state_d = START;
          end
        end else if (to_cnt_q == ADC_LIM) begin
          state_d = FAULT;
          fault_d = FLT_ADC_TO;
        end
      end
      START:    state_d = COMPUTE;
      COMPUTE:  begin
        if (mpc_done_i) begin
          state_d = APPLY;
        end else if (to_cnt_q == MPC_LIM) begin
          state_d = FAULT;
          fault_d = FLT_MPC_TO;
        end
      end
      APPLY:    state_d = IDLE;
      FAULT:    if (fault_clr_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (!enable_i && (state_q != FAULT)) begin
      state_d = IDLE;
      fault_d = FLT_NONE;
    end
  end

  // Event strobes derived from the current and next state.
  always_comb begin
    capture     = (state_q == WAIT_RDY) && adc_rdy_i && enable_i;
    apply       = (state_q == APPLY) && enable_i;
    change      = apply && (u_lat_q != u_q) && (dwell_q >= DWELL_MAX);
    fault_entry = (state_d == FAULT) && (state_q != FAULT);
    fault_exit  = (state_q == FAULT) && (state_d == IDLE);
  end

  // State register and shared handshake timeout counter (restarts on every
  // state change, so WAIT_RDY and COMPUTE each get a fresh budget).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d == state_q) && ((state_q == WAIT_RDY) || (state_q == COMPUTE)))
        to_cnt_q <= to_cnt_q + TO_W'(1);
      else
        to_cnt_q <= '0;
    end
  end

  // Operand and decision capture; operands stay put until the next capture.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      il_q    <= '0;
      vc_q    <= '0;
      vg_q    <= '0;
      u_lat_q <= 1'b0;
    end else begin
      if (capture) begin
        il_q <= adc_il_i;
        vc_q <= adc_vc_i;
        vg_q <= adc_vg_i;
      end
      if ((state_q == COMPUTE) && mpc_done_i)
        u_lat_q <= mpc_u_i;
    end
  end

  // Gate drive with minimum-dwell rule and completed-sample counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      u_q       <= 1'b0;
      dwell_q   <= DWELL_MAX;
      samples_q <= '0;
    end else begin
      if ((state_d == FAULT) || !enable_i)
        u_q <= 1'b0;
      else if (change)
        u_q <= u_lat_q;
      if (apply) begin
        if (change)
          dwell_q <= DWELL_ONE;
        else if (dwell_q < DWELL_MAX)
          dwell_q <= dwell_q + DW_W'(1);
        samples_q <= samples_q + 16'd1;
      end
    end
  end

  // Sticky trip/fault code, sticky overrun and pad output enable.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      trip_q <= 1'b0;
      code_q <= FLT_NONE;
      ovr_q  <= 1'b0;
      oeb_q  <= 1'b1;
    end else begin
      if (fault_entry) begin
        trip_q <= 1'b1;
        code_q <= fault_d;
      end else if (fault_exit) begin
        trip_q <= 1'b0;
        code_q <= FLT_NONE;
      end
      if (tick && (state_q != IDLE) && (state_q != FAULT))
        ovr_q <= 1'b1;
      else if (fault_clr_i)
        ovr_q <= 1'b0;
      oeb_q <= (state_d == FAULT) ? 1'b0 : ~enable_i;
    end
  end

  // Output decode; strobes are suppressed in the cycle enable drops.
  always_comb begin
    adc_conv_o   = (state_q == CONV) && enable_i;
    mpc_start_o  = (state_q == START) && enable_i;
    mpc_il_o     = il_q;
    mpc_vc_o     = vc_q;
    mpc_vg_o     = vg_q;
    u_o          = u_q;
    io_oeb_o     = oeb_q;
    trip_o       = trip_q;
    fault_code_o = code_q;
    overrun_o    = ovr_q;
    samples_o    = samples_q;
  end

endmodule

// File: tb/tb_fcs_mpc_sequencer.sv
// Self-checking bench for fcs_mpc_sequencer: directed phases with randomized
// operands/handshake delays against a behavioural model of the control cycle.
module tb_fcs_mpc_sequencer;

  localparam int unsigned PERIOD_W  = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADC_TO    = 64;
  localparam int unsigned MPC_TO    = 32;
  localparam int unsigned MIN_DWELL = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [15:0]       period = 16'd20;
  logic [7:0]        ilim = 8'd200;
  logic              fault_clr = 1'b0;
  logic              adc_conv;
  logic              adc_rdy = 1'b0;
  logic [7:0]        adc_il = '0, adc_vc = '0, adc_vg = '0;
  logic              mpc_start;
  logic [7:0]        mpc_il, mpc_vc, mpc_vg;
  logic              mpc_done = 1'b0;
  logic              mpc_u = 1'b0;
  logic              u;
  logic              oeb;
  logic              trip;
  logic [1:0]        fcode;
  logic              ovr;
  logic [15:0]       samples;

  fcs_mpc_sequencer #(
    .PERIOD_W (PERIOD_W), .DATA_W (DATA_W), .ADC_TO (ADC_TO),
    .MPC_TO (MPC_TO), .MIN_DWELL (MIN_DWELL)
  ) dut (
    .wb_clk_i (clk), .wb_rst_ni (rst_n), .enable_i (enable), .period_i (period),
    .ilim_i (ilim), .fault_clr_i (fault_clr), .adc_conv_o (adc_conv),
    .adc_rdy_i (adc_rdy), .adc_il_i (adc_il), .adc_vc_i (adc_vc), .adc_vg_i (adc_vg),
    .mpc_start_o (mpc_start), .mpc_il_o (mpc_il), .mpc_vc_o (mpc_vc), .mpc_vg_o (mpc_vg),
    .mpc_done_i (mpc_done), .mpc_u_i (mpc_u), .u_o (u), .io_oeb_o (oeb),
    .trip_o (trip), .fault_code_o (fcode), .overrun_o (ovr), .samples_o (samples)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state (spec-level quantities)
  int P = 20;           // effective sample period
  int m_u = 0;          // expected gate drive
  int m_since = MIN_DWELL; // applied samples since u last changed
  int m_samples = 0;
  int m_ovr = 0;
  int ref_cyc = 0;      // cycle of last conv (or enable)
  int exp_gap = -1;     // expected cycles to next conv, -1 = unknown phase

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Minimum-dwell rule applied to one completed sample
  task automatic model_apply(input int req);
    if (req != m_u && m_since >= MIN_DWELL) begin
      m_u = req;
      m_since = 1;
    end else begin
      m_since++;
    end
    m_samples = (m_samples + 1) % 65536;
  endtask

  // Wait (bounded) for the next ADC convert pulse and check its spacing
  task automatic wait_conv();
    int n = 0;
    do begin @(negedge clk); n++; end while (adc_conv !== 1'b1 && n < 400);
    chk("conv_seen", adc_conv, 1);
    if (exp_gap > 0) chk("conv_spacing", cyc - ref_cyc, exp_gap);
    ref_cyc = cyc;
  endtask

  // One full control cycle with ADC ready rd clocks after conv and core done
  // dd clocks after start
  task automatic run_cycle(input int rd, input int dd, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c, input logic uu);
    int k;
    wait_conv();
    chk("oeb_driving", oeb, 0);
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      if (i == 0) chk("conv_one_clock", adc_conv, 0);
      chk("no_early_start", mpc_start, 0);
    end
    adc_il = a; adc_vc = b; adc_vg = c; adc_rdy = 1'b1;
    @(negedge clk);
    adc_rdy = 1'b0; adc_il = 8'($urandom); adc_vc = 8'($urandom); adc_vg = 8'($urandom);
    chk("start_at_rdy_plus1", mpc_start, 1);
    chk("op_il", mpc_il, a);
    chk("op_vc", mpc_vc, b);
    chk("op_vg", mpc_vg, c);
    for (int i = 0; i < dd; i++) begin
      @(negedge clk);
      if (i == 0) chk("start_one_clock", mpc_start, 0);
    end
    chk("ops_stable", {mpc_il, mpc_vc, mpc_vg}, {a, b, c});
    mpc_u = uu; mpc_done = 1'b1;
    @(negedge clk);
    mpc_done = 1'b0; mpc_u = ~uu;
    chk("u_hold_done_plus1", u, m_u);
    model_apply(int'(uu));
    @(negedge clk);
    k = (rd + dd + 4 + P - 1) / P;
    if (k > 1) m_ovr = 1;
    chk("u_at_done_plus2", u, m_u);
    chk("samples", samples, m_samples);
    chk("overrun", ovr, m_ovr);
    exp_gap = k * P;
  endtask

  int dwell_req[6] = '{1, 0, 0, 1, 1, 0};
  int dwell_exp[6] = '{1, 1, 0, 0, 1, 1};
  int n;
  int pulses;

  initial begin
    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_u", u, 0);
    chk("rst_oeb", oeb, 1);
    chk("rst_trip", trip, 0);
    chk("rst_code", fcode, 0);
    chk("rst_samples", samples, 0);
    chk("rst_conv", adc_conv, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_dis_oeb", oeb, 1);

    // ---- nominal cycle, then dwell sequence on successive samples
    enable = 1'b1; ref_cyc = cyc; exp_gap = P;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) run_cycle(3, 5, 8'd40, 8'd100, 8'd50, 1'(dwell_req[i]));
      else run_cycle(3, 5, 8'($urandom_range(0, 199)), 8'($urandom), 8'($urandom), 1'(dwell_req[i]));
      chk("dwell_seq", u, dwell_exp[i]);
    end

    // ---- randomized cycles
    for (int i = 0; i < 12; i++)
      run_cycle($urandom_range(1, 8), $urandom_range(1, 10), 8'($urandom_range(0, 199)),
                8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // fault_clr outside FAULT clears only overrun
    fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0; m_ovr = 0;
    chk("clr_ovr_only", ovr, 0);
    chk("clr_keeps_u", u, m_u);

    // ---- overcurrent (il == ilim) from u_o = 1
    for (int i = 0; i < 3 && m_u != 1; i++)
      run_cycle(2, 3, 8'd10, 8'd20, 8'd30, 1'b1);
    chk("oc_pre_u", u, m_u);
    ilim = 8'd100;
    wait_conv();
    repeat (2) @(negedge clk);
    adc_il = 8'd100; adc_vc = 8'd7; adc_vg = 8'd9; adc_rdy = 1'b1;
    @(negedge clk); adc_rdy = 1'b0;
    m_u = 0;
    chk("oc_no_start", mpc_start, 0);
    chk("oc_u_low", u, 0);
    chk("oc_trip", trip, 1);
    chk("oc_code", fcode, 1);
    chk("oc_oeb", oeb, 0);
    chk("oc_il_capt", mpc_il, 100);
    pulses = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (i == 10) begin adc_rdy = 1'b1; mpc_done = 1'b1; end
      if (i == 11) begin adc_rdy = 1'b0; mpc_done = 1'b0; end
      if (adc_conv === 1'b1 || mpc_start === 1'b1) pulses++;
    end
    chk("fault_silent", pulses, 0);
    chk("fault_sticky", {trip, fcode}, 3'b101);
    chk("fault_no_ovr", ovr, 0);
    chk("fault_samples", samples, m_samples);
    fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
    chk("oc_clr_trip", trip, 0);
    chk("oc_clr_code", fcode, 0);
    ilim = 8'd200; exp_gap = -1;
    run_cycle(2, 3, 8'd99, 8'd1, 8'd2, 1'b1);

    // ---- ADC timeout
    wait_conv();
    n = 0;
    do begin @(negedge clk); n++; end while (trip !== 1'b1 && n < 200);
    m_u = 0;
    chk("adc_to_code", fcode, 2);
    chk("adc_to_delay_ok", (n > ADC_TO) && (n <= ADC_TO + 2), 1);
    chk("adc_to_u", u, 0);
    pulses = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      if (adc_conv === 1'b1) pulses++;
    end
    chk("adc_to_conv_silent", pulses, 0);
    fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
    chk("adc_to_clr", {trip, fcode}, 0);
    exp_gap = -1;

    // ---- MPC timeout
    wait_conv();
    @(negedge clk);
    adc_il = 8'd5; adc_vc = 8'd6; adc_vg = 8'd7; adc_rdy = 1'b1;
    @(negedge clk); adc_rdy = 1'b0;
    chk("mto_start", mpc_start, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (trip !== 1'b1 && n < 200);
    chk("mpc_to_code", fcode, 3);
    chk("mpc_to_delay_ok", (n > MPC_TO) && (n <= MPC_TO + 2), 1);
    fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
    chk("mpc_to_clr", trip, 0);
    exp_gap = -1;

    // ---- period clamp and overrun
    enable = 1'b0; repeat (2) @(negedge clk);
    m_u = 0;
    chk("dis_u", u, 0);
    chk("dis_oeb", oeb, 1);
    period = 16'd3; P = 8; m_ovr = 0;
    @(negedge clk);
    enable = 1'b1; ref_cyc = cyc; exp_gap = P;
    run_cycle(1, 10, 8'd11, 8'd22, 8'd33, 1'b1);
    run_cycle(1, 10, 8'd44, 8'd55, 8'd66, 1'b1);

    // ---- abort during COMPUTE
    enable = 1'b0; repeat (2) @(negedge clk);
    m_u = 0; period = 16'd20; P = 20;
    @(negedge clk);
    enable = 1'b1; ref_cyc = cyc; exp_gap = P;
    for (int i = 0; i < 3 && m_u != 1; i++)
      run_cycle(2, 3, 8'd12, 8'd34, 8'd56, 1'b1);
    chk("abort_pre_u", u, m_u);
    wait_conv();
    repeat (2) @(negedge clk);
    adc_il = 8'd1; adc_rdy = 1'b1;
    @(negedge clk); adc_rdy = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    m_u = 0;
    chk("abort_u", u, 0);
    chk("abort_oeb", oeb, 1);
    chk("abort_ovr", ovr, m_ovr);
    chk("abort_trip", trip, 0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      mpc_done = (i == 2);
      if (adc_conv === 1'b1 || mpc_start === 1'b1) pulses++;
    end
    chk("abort_no_pulses", pulses, 0);
    chk("abort_samples", samples, m_samples);
    enable = 1'b1; ref_cyc = cyc; exp_gap = P;
    run_cycle(4, 2, 8'd77, 8'd88, 8'd99, 1'b1);

    // ---- asynchronous reset with u_o = 1
    for (int i = 0; i < 3 && m_u != 1; i++)
      run_cycle(2, 3, 8'd13, 8'd14, 8'd15, 1'b1);
    chk("rst_pre_u", u, m_u);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_u", u, 0);
    chk("arst_oeb", oeb, 1);
    chk("arst_trip_code", {trip, fcode}, 0);
    chk("arst_ovr", ovr, 0);
    chk("arst_samples", samples, 0);
    chk("arst_ops", {mpc_il, mpc_vc, mpc_vg}, 0);
    chk("arst_pulses", {adc_conv, mpc_start}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fcs_mpc_sequencer.md
Name: fcs_mpc_sequencer

Overview:
- Sample-period sequencer for the FCS_MPC decision core.
- Each period it runs one full control cycle:
  - triggers the external ADC and waits for its ready strobe;
  - captures iL/vc/vg and checks overcurrent;
  - hands the operands to the MPC core and waits for its decision;
  - applies the switch command to the gate pad with a minimum-dwell rule.
- Sits between io_in/io_out pads and FCS_MPC in user_project_wrapper.
- Owns pad output enable, fault trip and overrun detection.

Parameters:
- PERIOD_W, 16, width of sample-period register.
- DATA_W, 8, width of each ADC/MPC operand.
- ADC_TO, 64, clocks allowed from adc_conv_o pulse to adc_rdy_i.
- MPC_TO, 32, clocks allowed from mpc_start_o to mpc_done_i.
- MIN_DWELL, 2, minimum applied samples u_o holds a value before it may change (>=1).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  run control.
- period_i  in  PERIOD_W  sample period in clocks; values <8 treated as 8.
- ilim_i  in  DATA_W  overcurrent threshold on iL.
- fault_clr_i  in  1  clears fault and overrun.
- adc_conv_o  out  1  one-clock ADC convert pulse.
- adc_rdy_i  in  1  ADC data valid (one or more clocks).
- adc_il_i, adc_vc_i, adc_vg_i  in  DATA_W each  ADC results.
- mpc_start_o  out  1  one-clock start pulse to core.
- mpc_il_o, mpc_vc_o, mpc_vg_o  out  DATA_W each  latched operands.
- mpc_done_i  in  1  core result valid.
- mpc_u_i  in  1  core switch decision.
- u_o  out  1  gate drive to pad.
- io_oeb_o  out  1  pad enable, active-low.
- trip_o  out  1  sticky fault.
- fault_code_o  out  2  00 none, 01 overcurrent, 10 ADC timeout, 11 MPC timeout.
- overrun_o  out  1  sticky; a tick arrived while not IDLE.
- samples_o  out  16  completed APPLY count, wraps.

Behaviour:
- Reset values:
  - all outputs 0, except io_oeb_o=1;
  - state IDLE; period counter 0; dwell_cnt=MIN_DWELL.
- Tick generator:
  - counts 0..P-1, where P=max(period_i,8);
  - tick is asserted in the cycle count==P-1;
  - counter is held at 0 while enable_i=0.
- period_i change: takes effect at the next wrap; a mid-period value below the current count does not extend the period.
- IDLE:
  - io_oeb_o=~enable_i;
  - enable_i=0 forces u_o=0;
  - on tick -> CONV.
- CONV: adc_conv_o=1 for exactly one clock -> WAIT_RDY.
- WAIT_RDY:
  - on adc_rdy_i, latch the three operands into mpc_*_o;
  - if captured il >= ilim_i -> FAULT(01);
  - else -> START;
  - ADC_TO clocks without adc_rdy_i -> FAULT(10).
- START: mpc_start_o=1 one clock -> COMPUTE. mpc_*_o stay stable until the next capture.
- COMPUTE:
  - on mpc_done_i, latch mpc_u_i -> APPLY;
  - MPC_TO clocks without done -> FAULT(11).
- APPLY, one clock:
  - if latched u differs from u_o and dwell_cnt>=MIN_DWELL: u_o<=u, dwell_cnt<=1;
  - else: u_o unchanged, dwell_cnt<=min(dwell_cnt+1, MIN_DWELL);
  - samples_o++;
  - -> IDLE.
- Latency: tick cycle T gives adc_conv_o at T+1. With rdy seen at cycle R:
  - mpc_start_o at R+1;
  - with done seen at D, u_o updates at D+2.
- FAULT:
  - u_o=0 from the next clock;
  - trip_o=1; fault_code held;
  - io_oeb_o stays 0 (driving low);
  - ignores ticks, adc_rdy_i and mpc_done_i;
  - enable_i=0 does not leave FAULT;
  - fault_clr_i -> IDLE, clearing trip_o, fault_code_o and overrun_o.
- Tick in any state other than IDLE:
  - overrun_o<=1 and the tick is dropped;
  - in FAULT, ticks are ignored without setting overrun.
- fault_clr_i outside FAULT clears only overrun_o.
- Simultaneous events:
  - tick in the same cycle as fault_clr_i in FAULT: the state only moves to IDLE; that tick is lost and does not set overrun.
  - a new fault condition in the same cycle as fault_clr_i: the fault wins.
- enable_i falling mid-cycle (not FAULT):
  - abort to IDLE next clock; u_o=0; io_oeb_o=1;
  - no pulses are issued; overrun_o and trip_o are unaffected.
- Asynchronous reset mid-operation: immediate return to reset values; u_o=0 without waiting for a clock.

Decomposition:
- fcs_mpc_pkg:
  - state enum {IDLE, CONV, WAIT_RDY, START, COMPUTE, APPLY, FAULT};
  - fault code localparams FLT_NONE/FLT_OC/FLT_ADC_TO/FLT_MPC_TO;
  - minimum period constant PERIOD_MIN=8.
- Sub-module fcs_mpc_tick_gen: period counter, clamp and tick output.
- The FSM, timeout counter, dwell logic and capture registers stay in fcs_mpc_sequencer.

Test Plan:
- Nominal cycle:
  - stimulus: period_i=20, ADC rdy 3 clocks after conv, data il=40 vc=100 vg=50, ilim_i=200, done 5 clocks after start with u=1;
  - required: conv at T+1, operands=40/100/50, start at rdy+1, u_o=1 at done+2, samples_o=1;
  - repeats every 20 clocks.
- Dwell, MIN_DWELL=2:
  - stimulus: core returns u=1,0,0,1,1,0 on successive samples from reset;
  - required: u_o=1,1,0,0,1,1.
- Overcurrent:
  - stimulus: ilim_i=100, ADC returns il=100;
  - required: no mpc_start_o, u_o=0 next clock, trip_o=1, fault_code_o=01;
  - then fault_clr_i pulse -> trip_o=0 and the next tick runs a normal cycle.
- Timeouts:
  - stimulus: no adc_rdy_i for 64 clocks;
  - required: fault_code_o=10 and adc_conv_o silent until clear;
  - separately, no done for 32 clocks -> fault_code_o=11.
- Overrun/clamp:
  - stimulus: period_i=3 (clamped to 8), core done after 12 clocks;
  - required: overrun_o=1, ticks spaced 8 clocks, every other tick dropped.
- Abort/reset:
  - stimulus: enable_i low during COMPUTE;
  - required: IDLE next clock, u_o=0, io_oeb_o=1;
  - stimulus: wb_rst_ni low with u_o=1;
  - required: u_o=0 asynchronously and all outputs at reset values.
